// File: rtl/win_capture_ctrl.sv
// rtl/win_capture_ctrl.sv - capture-window sequencer: pre-fill, arm, post-count, done; RAM write address gen.
// Optional auto-trigger timeout enabled by `define WIN_AUTO_TRIG_EN.
module win_capture_ctrl #(
    parameter int CNT_W      = 18,
    parameter int ADDR_W     = 10,
    parameter int AUTO_TICKS = 4096
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              CLK_EN,
    input  logic              Start_Write,
    input  logic [CNT_W-1:0]  PRE_DATA,
    input  logic [CNT_W-1:0]  WIN_DATA,
    input  logic              trigger_event_in,
    output logic              Wr_En,
    output logic [ADDR_W-1:0] Wr_Addr,
    output logic [ADDR_W-1:0] Trig_Addr,
    output logic              Pre_Ready,
    output logic              Write_Ready,
    output logic              Wrapped,
    output logic              Auto_Trig,
    output logic [2:0]        State
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    if (AUTO_TICKS < 1) begin : g_bad_auto_ticks
        $error("AUTO_TICKS must be at least 1");
    end

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    precnt_q, precnt_d;
    logic [CNT_W-1:0]    postcnt_q, postcnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
    logic                pre_rdy_q, pre_rdy_d;
    logic                wr_rdy_q, wr_rdy_d;
    logic                wrapped_q, wrapped_d;
    logic                active;
    logic                fire_real;
    logic                fire_auto;

    assign active    = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
    assign fire_real = (state_q == S_ARMED) && CLK_EN && trigger_event_in;

`ifdef WIN_AUTO_TRIG_EN
    localparam int AC_W = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;
    localparam logic [AC_W-1:0] AUTO_LAST = AC_W'(AUTO_TICKS - 1);

    logic [AC_W-1:0] armcnt_q, armcnt_d;
    logic            auto_q, auto_d;

    // A real trigger on the timeout tick takes precedence over the forced one.
    assign fire_auto = (state_q == S_ARMED) && CLK_EN && !trigger_event_in
                       && (armcnt_q == AUTO_LAST);
`else
    assign fire_auto = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!Start_Write) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_PRE;
                S_PRE:   if (CLK_EN && (precnt_q == '0)) state_d = S_ARMED;
                S_ARMED: if (fire_real || fire_auto) state_d = S_POST;
                S_POST:  if (CLK_EN && (postcnt_q == '0)) state_d = S_DONE;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        precnt_d    = precnt_q;
        postcnt_d   = postcnt_q;
        addr_d      = addr_q;
        trig_addr_d = trig_addr_q;
        pre_rdy_d   = pre_rdy_q;
        wr_rdy_d    = wr_rdy_q;
        wrapped_d   = wrapped_q;
`ifdef WIN_AUTO_TRIG_EN
        armcnt_d    = armcnt_q;
        auto_d      = auto_q;
`endif
        if (!Start_Write) begin
            precnt_d  = PRE_DATA;
            postcnt_d = WIN_DATA;
            addr_d    = '0;
            pre_rdy_d = 1'b0;
            wr_rdy_d  = 1'b0;
            wrapped_d = 1'b0;
`ifdef WIN_AUTO_TRIG_EN
            armcnt_d  = '0;
            auto_d    = 1'b0;
`endif
        end else begin
            // Window lengths are captured on leaving IDLE and frozen for the run.
            if (state_q == S_IDLE) begin
                precnt_d  = PRE_DATA;
                postcnt_d = WIN_DATA;
            end
            if (CLK_EN && active) begin
                addr_d = addr_q + 1'b1;
                if (addr_q == ADDR_MAX) wrapped_d = 1'b1;
            end
            if ((state_q == S_PRE) && CLK_EN) begin
                if (precnt_q == '0) begin
                    pre_rdy_d = 1'b1;
`ifdef WIN_AUTO_TRIG_EN
                    armcnt_d  = '0;
`endif
                end else begin
                    precnt_d = precnt_q - 1'b1;
                end
            end
            if ((state_q == S_ARMED) && CLK_EN) begin
                if (fire_real || fire_auto) trig_addr_d = addr_q;
`ifdef WIN_AUTO_TRIG_EN
                armcnt_d = armcnt_q + 1'b1;
                if (fire_auto) auto_d = 1'b1;
`endif
            end
            if ((state_q == S_POST) && CLK_EN) begin
                if (postcnt_q == '0) wr_rdy_d = 1'b1;
                else                 postcnt_d = postcnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            precnt_q    <= '0;
            postcnt_q   <= '0;
            addr_q      <= '0;
            trig_addr_q <= '0;
            pre_rdy_q   <= 1'b0;
            wr_rdy_q    <= 1'b0;
            wrapped_q   <= 1'b0;
`ifdef WIN_AUTO_TRIG_EN
            armcnt_q    <= '0;
            auto_q      <= 1'b0;
`endif
        end else begin
            precnt_q    <= precnt_d;
            postcnt_q   <= postcnt_d;
            addr_q      <= addr_d;
            trig_addr_q <= trig_addr_d;
            pre_rdy_q   <= pre_rdy_d;
            wr_rdy_q    <= wr_rdy_d;
            wrapped_q   <= wrapped_d;
`ifdef WIN_AUTO_TRIG_EN
            armcnt_q    <= armcnt_d;
            auto_q      <= auto_d;
`endif
        end
    end

    always_comb begin
        Wr_En       = CLK_EN && active;
        Wr_Addr     = addr_q;
        Trig_Addr   = trig_addr_q;
        Pre_Ready   = pre_rdy_q;
        Write_Ready = wr_rdy_q;
        Wrapped     = wrapped_q;
        State       = state_q;
`ifdef WIN_AUTO_TRIG_EN
        Auto_Trig   = auto_q;
`else
        Auto_Trig   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_win_capture_ctrl.sv
// tb/tb_win_capture_ctrl.sv - directed self-checking bench for win_capture_ctrl (10-bit and 4-bit address builds).
module tb_win_capture_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        CLK_EN;
    logic        Start_Write;
    logic [17:0] PRE_DATA;
    logic [17:0] WIN_DATA;
    logic        trig;

    logic        wr_en_a, pre_rdy_a, wr_rdy_a, wrapped_a, auto_a;
    logic [9:0]  wr_addr_a, trig_addr_a;
    logic [2:0]  state_a;
    logic        wr_en_b, pre_rdy_b, wr_rdy_b, wrapped_b, auto_b;
    logic [3:0]  wr_addr_b, trig_addr_b;
    logic [2:0]  state_b;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    win_capture_ctrl #(.CNT_W(18), .ADDR_W(10), .AUTO_TICKS(8)) u_dut (
        .CLK(CLK), .nRST(nRST), .CLK_EN(CLK_EN), .Start_Write(Start_Write),
        .PRE_DATA(PRE_DATA), .WIN_DATA(WIN_DATA), .trigger_event_in(trig),
        .Wr_En(wr_en_a), .Wr_Addr(wr_addr_a), .Trig_Addr(trig_addr_a),
        .Pre_Ready(pre_rdy_a), .Write_Ready(wr_rdy_a), .Wrapped(wrapped_a),
        .Auto_Trig(auto_a), .State(state_a)
    );

    win_capture_ctrl #(.CNT_W(18), .ADDR_W(4), .AUTO_TICKS(8)) u_dut4 (
        .CLK(CLK), .nRST(nRST), .CLK_EN(CLK_EN), .Start_Write(Start_Write),
        .PRE_DATA(PRE_DATA), .WIN_DATA(WIN_DATA), .trigger_event_in(trig),
        .Wr_En(wr_en_b), .Wr_Addr(wr_addr_b), .Trig_Addr(trig_addr_b),
        .Pre_Ready(pre_rdy_b), .Write_Ready(wr_rdy_b), .Wrapped(wrapped_b),
        .Auto_Trig(auto_b), .State(state_b)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; CLK_EN = 1'b0; Start_Write = 1'b0; trig = 1'b0;
        PRE_DATA = '0; WIN_DATA = '0;
        #3;
        checks++; if (state_a !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_a); end
        checks++; if (wr_addr_a !== 10'd0 || trig_addr_a !== 10'd0) begin errors++; $display("FAIL reset_addr got %0d/%0d exp 0/0", wr_addr_a, trig_addr_a); end
        checks++; if ({pre_rdy_a, wr_rdy_a, wrapped_a, auto_a} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {pre_rdy_a, wr_rdy_a, wrapped_a, auto_a}); end
        step();
        nRST = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [2:0] es;
        Start_Write = 1'b0; PRE_DATA = 18'd3; WIN_DATA = 18'd5; CLK_EN = 1'b1; trig = 1'b0;
        step();
        Start_Write = 1'b1;
        step();
        for (int t = 0; t < 12; t++) begin
            trig = (t == 5);
            es = (t < 4) ? 3'd1 : (t < 6) ? 3'd2 : 3'd3;
            #1;
            checks++; if (wr_en_a !== 1'b1) begin errors++; $display("FAIL basic_wr_en t=%0d got %b exp 1", t, wr_en_a); end
            checks++; if (wr_addr_a !== 10'(t)) begin errors++; $display("FAIL basic_addr t=%0d got %0d exp %0d", t, wr_addr_a, t); end
            checks++; if (state_a !== es) begin errors++; $display("FAIL basic_state t=%0d got %0d exp %0d", t, state_a, es); end
            checks++; if (pre_rdy_a !== (t >= 4)) begin errors++; $display("FAIL basic_pre_ready t=%0d got %b", t, pre_rdy_a); end
            checks++; if (wr_rdy_a !== 1'b0) begin errors++; $display("FAIL basic_early_ready t=%0d got %b exp 0", t, wr_rdy_a); end
            step();
        end
        trig = 1'b0;
        #1;
        checks++; if (state_a !== 3'd4 || wr_rdy_a !== 1'b1) begin errors++; $display("FAIL basic_done got state %0d ready %b exp 4/1", state_a, wr_rdy_a); end
        checks++; if (wr_addr_a !== 10'd12 || trig_addr_a !== 10'd5) begin errors++; $display("FAIL basic_final_addr got %0d/%0d exp 12/5", wr_addr_a, trig_addr_a); end
        checks++; if (wrapped_a !== 1'b0 || wr_en_a !== 1'b0) begin errors++; $display("FAIL basic_done_we got wrapped %b we %b exp 0/0", wrapped_a, wr_en_a); end
        step();
        checks++; if (state_a !== 3'd4 || wr_addr_a !== 10'd12) begin errors++; $display("FAIL basic_done_hold got %0d/%0d exp 4/12", state_a, wr_addr_a); end
    endtask

    task automatic test_trig_hold();
        logic [2:0] es;
        Start_Write = 1'b0; PRE_DATA = 18'd3; WIN_DATA = 18'd0; CLK_EN = 1'b1; trig = 1'b1;
        step();
        Start_Write = 1'b1;
        step();
        for (int t = 0; t < 6; t++) begin
            es = (t < 4) ? 3'd1 : (t == 4) ? 3'd2 : 3'd3;
            checks++; if (state_a !== es) begin errors++; $display("FAIL hold_state t=%0d got %0d exp %0d", t, state_a, es); end
            step();
        end
        checks++; if (state_a !== 3'd4) begin errors++; $display("FAIL hold_done got %0d exp 4", state_a); end
        checks++; if (trig_addr_a !== 10'd4 || wr_addr_a !== 10'd6) begin errors++; $display("FAIL hold_addr got %0d/%0d exp 4/6", trig_addr_a, wr_addr_a); end
        trig = 1'b0;
    endtask

    task automatic test_clk_en();
        Start_Write = 1'b0; PRE_DATA = 18'd3; WIN_DATA = 18'd5; CLK_EN = 1'b1; trig = 1'b0;
        step();
        Start_Write = 1'b1; CLK_EN = 1'b0;
        step();
        for (int t = 0; t < 12; t++) begin
            trig = (t == 5);
            CLK_EN = 1'b0;
            for (int g = 0; g < 2; g++) begin
                #1;
                checks++; if (wr_en_a !== 1'b0 || wr_addr_a !== 10'(t)) begin errors++; $display("FAIL clken_gap t=%0d got we %b addr %0d exp 0/%0d", t, wr_en_a, wr_addr_a, t); end
                step();
            end
            CLK_EN = 1'b1;
            #1;
            checks++; if (wr_en_a !== 1'b1 || wr_addr_a !== 10'(t)) begin errors++; $display("FAIL clken_tick t=%0d got we %b addr %0d exp 1/%0d", t, wr_en_a, wr_addr_a, t); end
            step();
        end
        CLK_EN = 1'b0; trig = 1'b0;
        #1;
        checks++; if (state_a !== 3'd4 || wr_addr_a !== 10'd12 || trig_addr_a !== 10'd5) begin errors++; $display("FAIL clken_final got %0d/%0d/%0d exp 4/12/5", state_a, wr_addr_a, trig_addr_a); end
    endtask

    task automatic test_abort();
        Start_Write = 1'b0; PRE_DATA = 18'd3; WIN_DATA = 18'd5; CLK_EN = 1'b1; trig = 1'b0;
        step();
        Start_Write = 1'b1;
        step();
        for (int t = 0; t < 8; t++) begin
            trig = (t == 4);
            step();
        end
        trig = 1'b0;
        checks++; if (state_a !== 3'd3 || wr_addr_a !== 10'd8) begin errors++; $display("FAIL abort_pre got %0d/%0d exp 3/8", state_a, wr_addr_a); end
        Start_Write = 1'b0;
        step();
        checks++; if (state_a !== 3'd0 || wr_addr_a !== 10'd0) begin errors++; $display("FAIL abort_state got %0d/%0d exp 0/0", state_a, wr_addr_a); end
        checks++; if (wr_rdy_a !== 1'b0 || pre_rdy_a !== 1'b0 || wr_en_a !== 1'b0) begin errors++; $display("FAIL abort_flags got %b%b%b exp 000", wr_rdy_a, pre_rdy_a, wr_en_a); end
        checks++; if (trig_addr_a !== 10'd4) begin errors++; $display("FAIL abort_trig_hold got %0d exp 4", trig_addr_a); end
    endtask

    task automatic test_wrap();
        Start_Write = 1'b0; PRE_DATA = 18'd20; WIN_DATA = 18'd2; CLK_EN = 1'b1; trig = 1'b0;
        step();
        Start_Write = 1'b1;
        step();
        for (int t = 0; t < 21; t++) begin
            checks++; if (wr_addr_b !== 4'(t)) begin errors++; $display("FAIL wrap_addr t=%0d got %0d exp %0d", t, wr_addr_b, t % 16); end
            checks++; if (wrapped_b !== (t >= 16)) begin errors++; $display("FAIL wrap_flag t=%0d got %b", t, wrapped_b); end
            checks++; if (state_b !== 3'd1) begin errors++; $display("FAIL wrap_state t=%0d got %0d exp 1", t, state_b); end
            step();
        end
        checks++; if (state_b !== 3'd2 || pre_rdy_b !== 1'b1 || wr_addr_b !== 4'd5) begin errors++; $display("FAIL wrap_armed got %0d/%b/%0d exp 2/1/5", state_b, pre_rdy_b, wr_addr_b); end
        checks++; if (wrapped_a !== 1'b0 || wr_addr_a !== 10'd21) begin errors++; $display("FAIL wrap_wide got %b/%0d exp 0/21", wrapped_a, wr_addr_a); end
    endtask

    task automatic test_auto_trig();
        trig = 1'b0; CLK_EN = 1'b1;
        for (int k = 0; k < 7; k++) step();
        checks++; if (state_a !== 3'd2 || auto_a !== 1'b0) begin errors++; $display("FAIL auto_early got %0d/%b exp 2/0", state_a, auto_a); end
        step();
`ifdef WIN_AUTO_TRIG_EN
        checks++; if (state_a !== 3'd3 || auto_a !== 1'b1) begin errors++; $display("FAIL auto_fire got %0d/%b exp 3/1", state_a, auto_a); end
        checks++; if (trig_addr_a !== 10'd28 || trig_addr_b !== 4'd12) begin errors++; $display("FAIL auto_addr got %0d/%0d exp 28/12", trig_addr_a, trig_addr_b); end
`else
        checks++; if (state_a !== 3'd2 || auto_a !== 1'b0) begin errors++; $display("FAIL auto_off got %0d/%b exp 2/0", state_a, auto_a); end
        for (int k = 0; k < 20; k++) step();
        checks++; if (state_b !== 3'd2 || auto_b !== 1'b0) begin errors++; $display("FAIL auto_wait got %0d/%b exp 2/0", state_b, auto_b); end
`endif
        Start_Write = 1'b0;
        step();
        checks++; if (auto_a !== 1'b0 || state_a !== 3'd0) begin errors++; $display("FAIL auto_clear got %b/%0d exp 0/0", auto_a, state_a); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_trig_hold();
        test_clk_en();
        test_abort();
        test_wrap();
        test_auto_trig();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
